// File: rtl/muldiv_sequencer.sv
// Multi-cycle MUL/DIVU/REMU sequencer that borrows the shared execute-stage ALU
// for every add/subtract step instead of carrying its own adder.
module muldiv_sequencer #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ITER = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            valid_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            ready_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [2:0]      alu_ctrl_o,
  output logic [XLEN-1:0] alu_data1_o,
  output logic [XLEN-1:0] alu_data2_o,
  input  logic [XLEN-1:0] alu_data_i
);

  localparam int unsigned CntW = $clog2(ITER);

  localparam logic [1:0] OpMul  = 2'd0;
  localparam logic [1:0] OpDivu = 2'd1;
  localparam logic [1:0] OpRemu = 2'd2;
  localparam logic [1:0] OpRsvd = 2'd3;

  localparam logic [2:0] AluAdd = 3'd0;
  localparam logic [2:0] AluSub = 3'd1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  // acc doubles as the partial remainder, mc as the quotient/dividend shifter,
  // mp as the divisor (held constant while dividing).
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] mc_q, mc_d;
  logic [XLEN-1:0] mp_q, mp_d;
  logic [XLEN-1:0] result_q, result_d;

  logic [XLEN:0]   trial;
  logic            ge;
  logic [XLEN-1:0] step_acc, step_mc, step_mp;

  always_comb begin
    trial = {acc_q, mc_q[XLEN-1]};
    ge    = (trial >= {1'b0, mp_q});
    if (op_q == OpMul) begin
      step_acc = mp_q[0] ? alu_data_i : acc_q;
      step_mc  = mc_q << 1;
      step_mp  = mp_q >> 1;
    end else begin
      // rem < dvs always holds, so the 32-bit ALU difference never wraps wrongly.
      step_acc = ge ? alu_data_i : trial[XLEN-1:0];
      step_mc  = {mc_q[XLEN-2:0], ge};
      step_mp  = mp_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mc_d        = mc_q;
    mp_d        = mp_q;
    result_d    = result_q;
    alu_ctrl_o  = AluAdd;
    alu_data1_o = '0;
    alu_data2_o = '0;

    unique case (state_q)
      StIdle: begin
        if (valid_i && !flush_i) begin
          op_d  = op_i;
          cnt_d = '0;
          acc_d = '0;
          mc_d  = rs1_i;
          mp_d  = rs2_i;
          if (op_i == OpRsvd) begin
            result_d = '0;
            state_d  = StDone;
          end else if (op_i != OpMul && rs2_i == '0) begin
            result_d = (op_i == OpDivu) ? '1 : rs1_i;
            state_d  = StDone;
          end else begin
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        alu_ctrl_o  = (op_q == OpMul) ? AluAdd : AluSub;
        alu_data1_o = (op_q == OpMul) ? acc_q : trial[XLEN-1:0];
        alu_data2_o = (op_q == OpMul) ? mc_q : mp_q;
        if (flush_i) begin
          state_d = StIdle;
        end else begin
          acc_d = step_acc;
          mc_d  = step_mc;
          mp_d  = step_mp;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(ITER - 1)) begin
            result_d = (op_q == OpDivu) ? step_mc : step_acc;
            state_d  = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= StIdle;
      op_q     <= OpMul;
      cnt_q    <= '0;
      acc_q    <= '0;
      mc_q     <= '0;
      mp_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mc_q     <= mc_d;
      mp_q     <= mp_d;
      result_q <= result_d;
    end
  end

  assign ready_o  = (state_q == StIdle);
  assign busy_o   = (state_q == StBusy);
  assign done_o   = (state_q == StDone);
  assign result_o = result_q;

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle RV32M-subset unit (MUL, DIVU, REMU) that computes by driving the shared 32-bit ALU iteratively instead of instantiating its own adder/subtractor.
- Sits beside the execute stage. While busy it owns the ALU operand/control mux and stalls the pipeline.
- The pipeline regains the ALU when the sequencer is idle.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- ITER, 32, iterations per MUL/DIV; must equal XLEN.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_n_i  in  1  synchronous active-low reset.
- valid_i  in  1  request strobe from the execute stage.
- op_i  in  2  operation select: 0=MUL (low 32 bits), 1=DIVU, 2=REMU, 3=reserved.
- rs1_i  in  32  multiplicand / dividend.
- rs2_i  in  32  multiplier / divisor.
- flush_i  in  1  abort the current operation.
- ready_o  out  1  high when idle and able to accept a request.
- busy_o  out  1  sequencer owns the ALU; the pipeline must stall and select the sequencer operands.
- done_o  out  1  one-cycle pulse; result_o is valid.
- result_o  out  32  result; holds its value until the next done_o.
- alu_ctrl_o  out  3  ALU operation code: 0=ADD, 1=SUB.
- alu_data1_o  out  32  ALU operand 1.
- alu_data2_o  out  32  ALU operand 2.
- alu_data_i  in  32  ALU result, combinational return path.

Behaviour:
- Reset (rst_n_i low at a clock edge, from any state):
  - state=IDLE; ready_o=1; busy_o=0; done_o=0; result_o=0.
  - alu_ctrl_o=0, alu_data1_o=0, alu_data2_o=0.
  - Counters and internal registers are cleared.
- States:
  - IDLE: ready_o=1; ALU outputs are driven to 0.
  - BUSY: busy_o=1; ready_o=0.
  - DONE: done_o=1 for exactly one cycle, then IDLE.
- Accept:
  - A request is accepted when valid_i & ready_o at edge T. Operands and op are latched; the iteration counter is cleared.
  - valid_i while not ready is ignored. No queueing.
- Fast paths (accepted at T, DONE in cycle T+1, BUSY skipped):
  - DIVU with rs2=0: result = 0xFFFFFFFF.
  - REMU with rs2=0: result = rs1.
  - op=3: result = 0.
- Normal path: BUSY for cycles T+1..T+32, DONE in cycle T+33, IDLE in T+34. ready_o=1 again in T+34.
- MUL iteration, with acc=0, mc=rs1, mp=rs2 at accept:
  - Drive alu_ctrl_o=ADD, data1=acc, data2=mc.
  - At the edge: if mp[0], acc <= alu_data_i. Then mc <= mc<<1 and mp <= mp>>1.
  - After 32 iterations, result = acc (mod 2^32).
- DIVU/REMU iteration, with rem=0, quo=rs1, dvs=rs2:
  - Form the 33-bit trial = {rem, quo[31]}.
  - Drive alu_ctrl_o=SUB, data1=trial[31:0], data2=dvs.
  - ge = (trial >= {1'b0,dvs}), using an internal 33-bit unsigned compare.
  - At the edge: rem <= ge ? alu_data_i : trial[31:0]; quo <= {quo[30:0], ge}.
  - Result: DIVU = quo, REMU = rem.
  - The ALU 32-bit wrap is correct because rem < dvs always holds.
- result_o is loaded on entry to DONE and is stable afterwards until the next DONE.
- flush_i:
  - In BUSY: next state is IDLE; no done_o; result_o is unchanged.
  - In DONE: done_o still pulses.
  - In IDLE: flush_i has priority over valid_i, so the request is not accepted.
- Reset mid-BUSY: returns to IDLE next edge per the reset values above; no done_o.
- The pipeline may present the next valid_i in the cycle ready_o returns high (T+34). That request is accepted at that edge.

Test Plan:
- Reset, then MUL 7 x 6 -> done_o exactly at T+33, result_o=42, busy_o high for 32 cycles, ready_o=1 at T+34.
- MUL 0xFFFFFFFF x 0xFFFFFFFF -> result_o=0x00000001. MUL 0x10000 x 0x10000 -> result_o=0.
- DIVU 100/7 -> 14. REMU 100/7 -> 2. DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF. REMU 0x80000000/0xFFFFFFFF -> 0x80000000. Each has done_o at T+33.
- DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, with done_o at T+1 and busy_o never high. op=3 -> result 0 at T+1.
- Flush and reset mid-op:
  - Start DIVU, assert flush_i at T+10 -> no done_o, ready_o=1 at T+11, result_o keeps its previous value.
  - Start MUL, pull rst_n_i low at T+5 -> all outputs at reset values next edge.
- valid_i held high continuously with varying operands -> exactly one accept per 34-cycle window. ALU outputs are 0 whenever busy_o=0.
